// File: rtl/lcd_pkg.sv
// Shared LCD definitions: transmit FSM states, default timings at 100 MHz,
// and the HD44780 command bytes used by the init/text sequencer.
// Pure declarations; no logic or timing of its own.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_HI,
    EN_HI,
    HOLD_HI,
    SETUP_LO,
    EN_LO,
    HOLD_LO
  } state_e;

  // Delay constants in clk cycles at 100 MHz.
  localparam int unsigned U400 = 40000;
  localparam int unsigned M1   = 100000;
  localparam int unsigned M2   = 200000;
  localparam int unsigned M30  = 3000000;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0F;
  localparam logic [7:0] CMD_FS_4BIT = 8'h28;

  // Clear and home are the slow instructions that need the extended hold.
  function automatic logic needs_long_hold(input logic [7:0] b, input logic rs);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_byte_tx_if.sv
// Byte request channel from the LCD sequencer to the nibble transmitter.
// One byte moves per cycle where in_valid and in_ready are both high.
// The transmitter (slave) drives in_ready; the sequencer drives the rest.
interface lcd_byte_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_rs;
  logic       in_nibble_only;

  modport master (
    output in_valid, in_byte, in_rs, in_nibble_only,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_byte, in_rs, in_nibble_only,
    output in_ready
  );
endinterface

// File: rtl/lcd_byte_tx.sv
// Purpose: send a byte (or a lone high nibble) to an HD44780 over its 4-bit bus with setup/enable/hold timing.
// Latency: pins driven the cycle after acceptance; occupies 2*(SETUP+EN+HOLD) cycles per byte (HOLD_LO may be LONG).
// Backpressure: in_ready only in IDLE outside reset; at least one IDLE cycle between transfers.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = U400,
  parameter int unsigned EN_CYC    = M1,
  parameter int unsigned HOLD_CYC  = U400,
  parameter int unsigned LONG_CYC  = M2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  lcd_byte_tx_if.slave  up,
  output logic          busy,
  output logic [3:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             nib_q, nib_d;
  logic [3:0]       data_q, data_d;
  logic             en_q, en_d;

  assign up.in_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign lcd_data    = data_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_en      = en_q;

  // Next state, counter and pin values; pins are registered from the next state so they never glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    nib_d    = nib_q;
    data_d   = data_q;
    cnt_last = '0;

    unique case (state_q)
      SETUP_HI, SETUP_LO: cnt_last = SETUP_LAST;
      EN_HI, EN_LO:       cnt_last = EN_LAST;
      HOLD_HI:            cnt_last = HOLD_LAST;
      HOLD_LO:            cnt_last = needs_long_hold(byte_q, rs_q) ? LONG_LAST : HOLD_LAST;
      default:            cnt_last = '0;
    endcase

    if (state_q == IDLE) begin
      if (up.in_valid) begin
        byte_d  = up.in_byte;
        rs_d    = up.in_rs;
        nib_d   = up.in_nibble_only;
        data_d  = up.in_byte[7:4];
        state_d = SETUP_HI;
        cnt_d   = '0;
      end
    end else if (cnt_q == cnt_last) begin
      cnt_d = '0;
      unique case (state_q)
        SETUP_HI: state_d = EN_HI;
        EN_HI:    state_d = HOLD_HI;
        HOLD_HI: begin
          if (nib_q) begin
            state_d = IDLE;
          end else begin
            state_d = SETUP_LO;
            data_d  = byte_q[3:0];
          end
        end
        SETUP_LO: state_d = EN_LO;
        EN_LO:    state_d = HOLD_LO;
        HOLD_LO:  state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    en_d = (state_d == EN_HI) || (state_d == EN_LO);
  end

  // State, counter, latched request and pin registers; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_lcd_byte_tx.sv
// Directed bench for lcd_byte_tx with short timings (setup 4, enable 6, hold 3, long 20).
// Every busy cycle of each transfer is compared against a phase-length waveform built here.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_lcd_byte_tx;

  localparam int S_C = 4;
  localparam int E_C = 6;
  localparam int H_C = 3;
  localparam int L_C = 20;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [3:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  int checks = 0;
  int errors = 0;

  lcd_byte_tx_if up_if ();

  lcd_byte_tx #(
    .SETUP_CYC (S_C),
    .EN_CYC    (E_C),
    .HOLD_CYC  (H_C),
    .LONG_CYC  (L_C),
    .CNT_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up_if),
    .busy     (busy),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the first busy cycle after the accepting edge; walks the whole
  // transfer cycle by cycle and ends on the first IDLE cycle that follows.
  task automatic run_xfer(input logic [7:0] b, input logic rs, input logic nib);
    int len[6];
    int total;
    int phases;
    int p;
    int acc;
    logic [3:0] exp_d;
    len[0] = S_C; len[1] = E_C; len[2] = H_C;
    len[3] = S_C; len[4] = E_C;
    len[5] = (!nib && !rs && (b == 8'h01 || b == 8'h02)) ? L_C : H_C;
    phases = nib ? 3 : 6;
    total = 0;
    for (int i = 0; i < phases; i++) total += len[i];
    for (int k = 0; k < total; k++) begin
      p = 0;
      acc = len[0];
      while (k >= acc) begin
        p++;
        acc += len[p];
      end
      exp_d = (p < 3) ? b[7:4] : b[3:0];
      chk($sformatf("busy[%0h c%0d]", b, k), {7'd0, busy}, 8'd1);
      chk($sformatf("ready[%0h c%0d]", b, k), {7'd0, up_if.in_ready}, 8'd0);
      chk($sformatf("en[%0h c%0d]", b, k), {7'd0, lcd_en}, {7'd0, (p == 1 || p == 4)});
      chk($sformatf("data[%0h c%0d]", b, k), {4'd0, lcd_data}, {4'd0, exp_d});
      chk($sformatf("rs[%0h c%0d]", b, k), {7'd0, lcd_rs}, {7'd0, rs});
      chk($sformatf("rw[%0h c%0d]", b, k), {7'd0, lcd_rw}, 8'd0);
      step();
    end
    exp_d = nib ? b[7:4] : b[3:0];
    chk($sformatf("idle_busy[%0h]", b), {7'd0, busy}, 8'd0);
    chk($sformatf("idle_ready[%0h]", b), {7'd0, up_if.in_ready}, 8'd1);
    chk($sformatf("idle_en[%0h]", b), {7'd0, lcd_en}, 8'd0);
    chk($sformatf("idle_data[%0h]", b), {4'd0, lcd_data}, {4'd0, exp_d});
    chk($sformatf("idle_rs[%0h]", b), {7'd0, lcd_rs}, {7'd0, rs});
  endtask

  // Single handshake from IDLE, then scrambles the inputs while the transfer runs.
  task automatic send(input logic [7:0] b, input logic rs, input logic nib);
    chk($sformatf("pre_ready[%0h]", b), {7'd0, up_if.in_ready}, 8'd1);
    up_if.in_valid       = 1'b1;
    up_if.in_byte        = b;
    up_if.in_rs          = rs;
    up_if.in_nibble_only = nib;
    step();
    up_if.in_valid       = 1'b0;
    up_if.in_byte        = ~b;
    up_if.in_rs          = ~rs;
    up_if.in_nibble_only = ~nib;
    run_xfer(b, rs, nib);
  endtask

  initial begin
    rst                  = 1'b1;
    up_if.in_valid       = 1'b0;
    up_if.in_byte        = 8'h00;
    up_if.in_rs          = 1'b0;
    up_if.in_nibble_only = 1'b0;

    // Reset held for three edges: everything low, not ready.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_en%0d", i), {7'd0, lcd_en}, 8'd0);
      chk($sformatf("rst_data%0d", i), {4'd0, lcd_data}, 8'd0);
      chk($sformatf("rst_rs%0d", i), {7'd0, lcd_rs}, 8'd0);
      chk($sformatf("rst_rw%0d", i), {7'd0, lcd_rw}, 8'd0);
      chk($sformatf("rst_busy%0d", i), {7'd0, busy}, 8'd0);
      chk($sformatf("rst_ready%0d", i), {7'd0, up_if.in_ready}, 8'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_ready", {7'd0, up_if.in_ready}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("idle_en_quiet%0d", i), {7'd0, lcd_en}, 8'd0);
      step();
    end

    // Data byte, nibble-only wake-up, clear with and without rs, home, nibble data.
    send(8'h4D, 1'b1, 1'b0);
    send(8'h30, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b1);
    send(8'h5A, 1'b1, 1'b1);

    // Valid held across two bytes; the second is taken on the first IDLE cycle.
    chk("b2b_ready", {7'd0, up_if.in_ready}, 8'd1);
    up_if.in_valid       = 1'b1;
    up_if.in_byte        = 8'h28;
    up_if.in_rs          = 1'b0;
    up_if.in_nibble_only = 1'b0;
    step();
    up_if.in_byte = 8'h06;
    run_xfer(8'h28, 1'b0, 1'b0);
    step();
    up_if.in_valid = 1'b0;
    up_if.in_byte  = 8'hC3;
    up_if.in_rs    = 1'b1;
    run_xfer(8'h06, 1'b0, 1'b0);

    // Reset in the third cycle of the low-nibble enable pulse.
    up_if.in_valid       = 1'b1;
    up_if.in_byte        = 8'h4D;
    up_if.in_rs          = 1'b1;
    up_if.in_nibble_only = 1'b0;
    step();
    up_if.in_valid = 1'b0;
    for (int i = 0; i < S_C + E_C + H_C + S_C + 2; i++) step();
    chk("mid_en_high", {7'd0, lcd_en}, 8'd1);
    chk("mid_data_lo", {4'd0, lcd_data}, 8'h0D);
    rst = 1'b1;
    step();
    chk("abort_en", {7'd0, lcd_en}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_ready_in_rst", {7'd0, up_if.in_ready}, 8'd0);
    rst = 1'b0;
    step();
    chk("abort_ready_after", {7'd0, up_if.in_ready}, 8'd1);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("no_replay_en%0d", i), {7'd0, lcd_en}, 8'd0);
      chk($sformatf("no_replay_busy%0d", i), {7'd0, busy}, 8'd0);
      step();
    end

    // Normal traffic resumes after the abort.
    send(8'h0F, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
